vtiming_rx: RTL and testbench
=============================

Name: vtiming_rx

Overview:
Sink-side VGA timing decoder. It samples a raw Hsync/Vsync pair, for example looped back from the 800x525 generator's outputs. It recovers pixel and line position, measures line length, frame length and sync widths, and asserts Locked once the timing is stable. It is used for sync loopback self-test and as the front end of a future capture path.

Parameters:
XBITS, 10, width of pixel counters and horizontal measurements
YBITS, 10, width of line counters and vertical measurements
HSYNC_POL, 0, active level of InHsync (0 = active-low)
VSYNC_POL, 0, active level of InVsync (0 = active-low)
LOCK_FRAMES, 2, consecutive clean frames required to assert Locked (1..7)

Ports:
PixelClkSrc  in  1  pixel clock; all logic on its rising edge
SysRstN  in  1  asynchronous, active-low reset
InHsync  in  1  raw horizontal sync; may be asynchronous
InVsync  in  1  raw vertical sync; may be asynchronous
HPos  out  XBITS  cycles since the last hsync leading edge
VPos  out  YBITS  hsync leading edges since the last vsync leading edge
LineLen  out  XBITS  cycles between the last two hsync leading edges
HsyncLen  out  XBITS  hsync active width of the last line, in cycles
FrameLen  out  YBITS  lines in the last complete frame
VsyncLen  out  YBITS  hsync leading edges seen while vsync was active
Locked  out  1  timing stable
FrameStart  out  1  one-cycle pulse on each vsync leading edge
LockLost  out  1  one-cycle pulse when leaving LOCKED

Behaviour:
- Reset: async assert, sync release. Every output and internal register returns to 0. FSM enters SEEK.
- Input path: 2-flop synchronizer per sync input, then a previous-value register. Active level is normalized through HSYNC_POL/VSYNC_POL.
- Edge definitions: lead = active & ~prev_active; trail = ~active & prev_active.
- Latency: registered results update on the 3rd PixelClkSrc edge after a pin transition.
- Hsync lead:
  - LineLen <= HPos+1.
  - HPos <= 0.
  - VPos <= VPos+1, saturating.
- Hsync idle cycles: HPos increments, saturating at 2^XBITS-1.
- Hsync trail: HsyncLen <= HPos+1.
- Vsync lead:
  - FrameStart = 1.
  - FrameLen <= VPos.
  - VPos <= 0, or 1 if hsync lead occurs in the same cycle. A coincident hsync lead counts as line 0 of the new frame.
  - The VsyncLen accumulator clears.
- VsyncLen counting: each hsync lead while vsync is active increments the accumulator. Vsync trail copies it to VsyncLen.
- Clean-frame tracking: the first hsync lead after a vsync lead stores RefLine. Every later hsync lead in that frame compares LineLen with RefLine; a mismatch sets FrameBad.
- Timeout: HPos reaching its saturation value sets FrameBad and forces SEEK.
- FSM states: SEEK, MEASURE, LOCKED. Match counter MCnt is 3 bits.
  - SEEK -> MEASURE on the first vsync lead. MCnt=0, RefFrame=0.
  - MEASURE, on vsync lead with frame clean (FrameBad=0 and RefFrame is 0 or equals VPos): MCnt+1, RefFrame <= VPos. Go to LOCKED when MCnt+1 == LOCK_FRAMES.
  - MEASURE, on vsync lead with frame not clean: MCnt <= 0, RefFrame <= VPos.
  - LOCKED, leaving: a line-length mismatch at an hsync lead, a frame-length mismatch at a vsync lead, or a timeout. LockLost pulses and Locked drops on the same edge.
  - Leaving LOCKED on mismatch goes to MEASURE with MCnt=0. Leaving on timeout goes to SEEK.
- Locked is a registered decode: high only in LOCKED.
- Measurement outputs keep updating in every state and are valid only while Locked=1.

Test Plan:
- Standard timing: line = 800 cycles, hsync active cycles 657..752, vsync active lines 491..492, 525 lines; SysRstN released -> LineLen=800, HsyncLen=96, FrameLen=525, VsyncLen=2. Locked rises 3 clocks after the 3rd vsync leading edge; FrameStart pulses once per 420000 cycles.
- Locked, then one line stretched to 801 cycles -> LockLost pulse 3 clocks after that line's closing hsync edge, Locked=0. Relock at the 2nd clean vsync lead after the disturbed frame ends.
- Locked, then InHsync held inactive -> HPos reaches 1023, LockLost pulses, FSM returns to SEEK. Resuming normal timing relocks after 3 vsync leads.
- HSYNC_POL=1, VSYNC_POL=1 with inverted inputs -> identical measured values and lock timing as the standard-timing case.
- SysRstN pulsed low mid-frame while locked -> all outputs 0 immediately, with no clock needed. After release, Locked=0 until the 3rd vsync lead.
- Hsync and vsync leading edges in the same cycle -> VPos=1 on the next clock and FrameLen equals the line count of the previous frame. A 525-line stream with coincident edges measures FrameLen=525.

Source files
------------

// File: rtl/vtiming_rx_if.sv
// Raw sync inputs and recovered timing measurements for vtiming_rx.
// The sync source drives through master; the decoder attaches as slave.
interface vtiming_rx_if #(
  parameter int XBITS = 10,
  parameter int YBITS = 10
);
  logic             InHsync;
  logic             InVsync;
  logic [XBITS-1:0] HPos;
  logic [YBITS-1:0] VPos;
  logic [XBITS-1:0] LineLen;
  logic [XBITS-1:0] HsyncLen;
  logic [YBITS-1:0] FrameLen;
  logic [YBITS-1:0] VsyncLen;
  logic             Locked;
  logic             FrameStart;
  logic             LockLost;

  modport master (
    output InHsync, InVsync,
    input  HPos, VPos, LineLen, HsyncLen, FrameLen, VsyncLen,
    input  Locked, FrameStart, LockLost
  );

  modport slave (
    input  InHsync, InVsync,
    output HPos, VPos, LineLen, HsyncLen, FrameLen, VsyncLen,
    output Locked, FrameStart, LockLost
  );
endinterface

// File: rtl/vtiming_rx.sv
// Sink-side VGA timing decoder: recovers pixel/line position, measures line,
// frame and sync widths, and declares lock after enough consecutive clean frames.
module vtiming_rx #(
  parameter int XBITS       = 10,
  parameter int YBITS       = 10,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        PixelClkSrc,
  input  logic        SysRstN,
  vtiming_rx_if.slave vt
);

  localparam logic [1:0] SEEK    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  localparam logic [XBITS-1:0] XONE        = {{(XBITS-1){1'b0}}, 1'b1};
  localparam logic [YBITS-1:0] YONE        = {{(YBITS-1){1'b0}}, 1'b1};
  localparam logic [XBITS-1:0] XMAX        = '1;
  localparam logic [YBITS-1:0] YMAX        = '1;
  localparam logic [2:0]       LOCK_TARGET = 3'(LOCK_FRAMES);

  logic [1:0]       rstSync;
  logic             rstN;
  logic [1:0]       hSync, vSync;
  logic             hPrev, vPrev;
  logic             hActive, vActive, hLead, hTrail, vLead, vTrail;
  logic [XBITS-1:0] hPos, lineLen, hsyncLen, refLine, hPosInc;
  logic [YBITS-1:0] vPos, frameLen, vsyncLen, vAcc, refFrame, refFrameNext;
  logic             refValid, frameBad;
  logic             timeout, storeRef, lineMis, frameClean;
  logic [1:0]       state, stateNext;
  logic [2:0]       mCnt, mCntNext, mCntInc;
  logic             locked, frameStart, lockLost;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge PixelClkSrc or negedge SysRstN) begin
    if (!SysRstN) rstSync <= 2'b00;
    else          rstSync <= {rstSync[0], 1'b1};
  end
  assign rstN = rstSync[1];

  // Polarity is normalized before the synchronizer so a cleared register reads as idle.
  always_ff @(posedge PixelClkSrc or negedge rstN) begin
    if (!rstN) begin
      hSync <= 2'b00;
      vSync <= 2'b00;
      hPrev <= 1'b0;
      vPrev <= 1'b0;
    end else begin
      hSync <= {hSync[0], vt.InHsync == HSYNC_POL};
      vSync <= {vSync[0], vt.InVsync == VSYNC_POL};
      hPrev <= hActive;
      vPrev <= vActive;
    end
  end

  assign hActive = hSync[1];
  assign vActive = vSync[1];
  assign hLead   = hActive & ~hPrev;
  assign hTrail  = ~hActive & hPrev;
  assign vLead   = vActive & ~vPrev;
  assign vTrail  = ~vActive & vPrev;

  assign hPosInc    = hPos + XONE;
  assign timeout    = (hPos == XMAX);
  assign storeRef   = hLead & (vLead | ~refValid);
  assign lineMis    = hLead & ~storeRef & (hPosInc != refLine);
  assign frameClean = ~frameBad & ((refFrame == '0) | (refFrame == vPos));
  assign mCntInc    = mCnt + 3'd1;

  // A coincident hsync lead becomes line 0 of the new frame, hence the vLead overrides.
  always_ff @(posedge PixelClkSrc or negedge rstN) begin
    if (!rstN) begin
      hPos     <= '0;
      vPos     <= '0;
      lineLen  <= '0;
      hsyncLen <= '0;
      frameLen <= '0;
      vsyncLen <= '0;
      vAcc     <= '0;
      refLine  <= '0;
      refValid <= 1'b0;
      frameBad <= 1'b0;
    end else begin
      if (hLead) begin
        lineLen <= hPosInc;
        hPos    <= '0;
        if (vPos != YMAX) vPos <= vPos + YONE;
      end else if (!timeout) begin
        hPos <= hPosInc;
      end
      if (hTrail) hsyncLen <= hPosInc;

      if (vLead) begin
        frameLen <= vPos;
        vPos     <= hLead ? YONE : '0;
        vAcc     <= hLead ? YONE : '0;
        frameBad <= 1'b0;
      end else if (hLead && vActive && vAcc != YMAX) begin
        vAcc <= vAcc + YONE;
      end
      if (vTrail) vsyncLen <= vAcc;

      if (storeRef) begin
        refLine  <= hPosInc;
        refValid <= 1'b1;
      end else if (vLead) begin
        refValid <= 1'b0;
      end
      if (lineMis || timeout) frameBad <= 1'b1;
    end
  end

  always_comb begin
    stateNext    = state;
    mCntNext     = mCnt;
    refFrameNext = refFrame;
    case (state)
      SEEK: begin
        if (vLead) begin
          stateNext    = MEASURE;
          mCntNext     = '0;
          refFrameNext = '0;
        end
      end
      MEASURE: begin
        if (vLead) begin
          refFrameNext = vPos;
          if (frameClean) begin
            mCntNext = mCntInc;
            if (mCntInc == LOCK_TARGET) stateNext = LOCKED;
          end else begin
            mCntNext = '0;
          end
        end
      end
      LOCKED: begin
        if (lineMis) begin
          stateNext = MEASURE;
          mCntNext  = '0;
        end else if (vLead && vPos != refFrame) begin
          stateNext    = MEASURE;
          mCntNext     = '0;
          refFrameNext = vPos;
        end
      end
      default: stateNext = SEEK;
    endcase
    if (timeout) begin
      stateNext = SEEK;
      mCntNext  = '0;
    end
  end

  always_ff @(posedge PixelClkSrc or negedge rstN) begin
    if (!rstN) begin
      state      <= SEEK;
      mCnt       <= '0;
      refFrame   <= '0;
      locked     <= 1'b0;
      frameStart <= 1'b0;
      lockLost   <= 1'b0;
    end else begin
      state      <= stateNext;
      mCnt       <= mCntNext;
      refFrame   <= refFrameNext;
      locked     <= (stateNext == LOCKED);
      frameStart <= vLead;
      lockLost   <= (state == LOCKED) && (stateNext != LOCKED);
    end
  end

  assign vt.HPos       = hPos;
  assign vt.VPos       = vPos;
  assign vt.LineLen    = lineLen;
  assign vt.HsyncLen   = hsyncLen;
  assign vt.FrameLen   = frameLen;
  assign vt.VsyncLen   = vsyncLen;
  assign vt.Locked     = locked;
  assign vt.FrameStart = frameStart;
  assign vt.LockLost   = lockLost;

endmodule

// File: tb/tb_vtiming_rx.sv
// Directed bench for vtiming_rx on a reduced 80x20 raster (hsync pixels 64..71,
// vsync lines 16..17); a second instance sees inverted pins with active-high polarity.
`timescale 1ns/1ps
module tb_vtiming_rx;
  localparam int LINE_PIX    = 80;
  localparam int FRAME_LINES = 20;
  localparam int V_START     = 16;
  localparam int V_END       = 18;

  logic pixelClk = 1'b0;
  logic sysRstN  = 1'b1;
  int   pix = 0;
  int   lineIdx = 0;
  int   hStart = 64;
  int   hWidth = 8;
  int   stretchLine = -1;
  bit   holdOn = 1'b0;
  int   checkCount = 0;
  int   errCount = 0;
  int   fsCount = 0;
  int   fsBase;

  vtiming_rx_if #(.XBITS(10), .YBITS(10)) vtA ();
  vtiming_rx_if #(.XBITS(10), .YBITS(10)) vtB ();

  vtiming_rx #(.XBITS(10), .YBITS(10), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .LOCK_FRAMES(2)) dutA (
    .PixelClkSrc(pixelClk),
    .SysRstN    (sysRstN),
    .vt         (vtA)
  );

  vtiming_rx #(.XBITS(10), .YBITS(10), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .LOCK_FRAMES(2)) dutB (
    .PixelClkSrc(pixelClk),
    .SysRstN    (sysRstN),
    .vt         (vtB)
  );

  always #5 pixelClk = ~pixelClk;

  always @(negedge pixelClk) if (vtA.FrameStart) fsCount++;

  task automatic checkOutput(input string tag, input int got, input int exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drives one pixel of the raster per clock, then returns just after the next rising edge.
  task automatic applyStimulus(input int n);
    bit hAct, vAct;
    int curLen;
    for (int i = 0; i < n; i++) begin
      hAct = (pix >= hStart) && (pix < hStart + hWidth) && !(holdOn && lineIdx >= 1 && lineIdx <= 14);
      vAct = (lineIdx >= V_START) && (lineIdx < V_END);
      vtA.InHsync = ~hAct;
      vtA.InVsync = ~vAct;
      vtB.InHsync = hAct;
      vtB.InVsync = vAct;
      curLen = (lineIdx == stretchLine) ? LINE_PIX + 1 : LINE_PIX;
      pix++;
      if (pix >= curLen) begin
        pix = 0;
        if (lineIdx == stretchLine) stretchLine = -1;
        if (holdOn && lineIdx == 14) holdOn = 1'b0;
        lineIdx = (lineIdx + 1) % FRAME_LINES;
      end
      @(posedge pixelClk);
      #1;
    end
  endtask

  task automatic runToNext(input int l, input int p);
    applyStimulus(1);
    for (int k = 0; k < 2 * LINE_PIX * FRAME_LINES && !(lineIdx == l && pix == p); k++)
      applyStimulus(1);
  endtask

  task automatic checkLock(input string tag, input int expLocked, input int expLost);
    checkOutput({tag, " Locked/A"}, vtA.Locked, expLocked);
    checkOutput({tag, " Locked/B"}, vtB.Locked, expLocked);
    checkOutput({tag, " LockLost/A"}, vtA.LockLost, expLost);
    checkOutput({tag, " LockLost/B"}, vtB.LockLost, expLost);
  endtask

  task automatic checkMeas(input string tag, input int eLine, input int eHs, input int eFrame, input int eVs);
    checkOutput({tag, " LineLen/A"}, vtA.LineLen, eLine);
    checkOutput({tag, " LineLen/B"}, vtB.LineLen, eLine);
    checkOutput({tag, " HsyncLen/A"}, vtA.HsyncLen, eHs);
    checkOutput({tag, " HsyncLen/B"}, vtB.HsyncLen, eHs);
    checkOutput({tag, " FrameLen/A"}, vtA.FrameLen, eFrame);
    checkOutput({tag, " FrameLen/B"}, vtB.FrameLen, eFrame);
    checkOutput({tag, " VsyncLen/A"}, vtA.VsyncLen, eVs);
    checkOutput({tag, " VsyncLen/B"}, vtB.VsyncLen, eVs);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " HPos"}, vtA.HPos, 0);
    checkOutput({tag, " VPos"}, vtA.VPos, 0);
    checkOutput({tag, " FrameStart"}, vtA.FrameStart, 0);
    checkLock(tag, 0, 0);
    checkMeas(tag, 0, 0, 0, 0);
  endtask

  initial begin
    $display("[TB] vtiming_rx directed test start");
    sysRstN = 1'b0;
    applyStimulus(3);
    checkAllZero("reset");
    sysRstN = 1'b1;

    // Standard timing: lock 3 clocks after the 3rd vsync lead.
    repeat (3) runToNext(V_START, 0);
    applyStimulus(2);
    checkLock("lock-2clk", 0, 0);
    applyStimulus(1);
    checkLock("lock-3clk", 1, 0);
    checkOutput("lock FrameStart/A", vtA.FrameStart, 1);
    applyStimulus(1);
    checkOutput("FrameStart pulse end/A", vtA.FrameStart, 0);
    runToNext(19, 0);
    checkMeas("std", 80, 8, 20, 2);
    checkOutput("std HPos/A", vtA.HPos, 13);
    checkOutput("std HPos/B", vtB.HPos, 13);
    checkOutput("std VPos/A", vtA.VPos, 3);
    checkOutput("std VPos/B", vtB.VPos, 3);
    fsBase = fsCount;
    applyStimulus(LINE_PIX * FRAME_LINES);
    checkOutput("FrameStart per frame", fsCount - fsBase, 1);

    // One 81-cycle line breaks lock at its closing hsync edge.
    stretchLine = 5;
    runToNext(6, 64);
    applyStimulus(2);
    checkLock("stretch-2clk", 1, 0);
    applyStimulus(1);
    checkLock("stretch-3clk", 0, 1);
    checkOutput("stretch LineLen/A", vtA.LineLen, 81);
    applyStimulus(1);
    checkLock("stretch-4clk", 0, 0);
    runToNext(V_START, 0);
    runToNext(V_START, 0);
    applyStimulus(3);
    checkLock("relock-1st-clean", 0, 0);
    runToNext(V_START, 0);
    applyStimulus(2);
    checkLock("relock-2nd-clean-2clk", 0, 0);
    applyStimulus(1);
    checkLock("relock-2nd-clean-3clk", 1, 0);

    // Hsync withheld for lines 1..14 saturates HPos and times out.
    runToNext(0, 72);
    holdOn = 1'b1;
    runToNext(13, 49);
    applyStimulus(1);
    checkOutput("timeout HPos/A", vtA.HPos, 1023);
    checkOutput("timeout HPos/B", vtB.HPos, 1023);
    checkLock("timeout-pre", 1, 0);
    applyStimulus(1);
    checkLock("timeout", 0, 1);
    applyStimulus(1);
    checkLock("timeout-post", 0, 0);
    checkOutput("timeout hold HPos/A", vtA.HPos, 1023);
    runToNext(V_START, 0);
    runToNext(V_START, 0);
    applyStimulus(3);
    checkLock("tmo-relock-2nd", 0, 0);
    runToNext(V_START, 0);
    applyStimulus(2);
    checkLock("tmo-relock-3rd-2clk", 0, 0);
    applyStimulus(1);
    checkLock("tmo-relock-3rd-3clk", 1, 0);

    // Asynchronous reset mid-frame clears outputs with no clock edge.
    runToNext(8, 10);
    sysRstN = 1'b0;
    #1;
    checkAllZero("async-reset");
    #2;
    applyStimulus(3);
    sysRstN = 1'b1;
    runToNext(V_START, 0);
    runToNext(V_START, 0);
    applyStimulus(3);
    checkLock("rst-relock-2nd", 0, 0);
    runToNext(V_START, 0);
    applyStimulus(2);
    checkLock("rst-relock-3rd-2clk", 0, 0);
    applyStimulus(1);
    checkLock("rst-relock-3rd-3clk", 1, 0);

    // Hsync lead moved to pixel 0 so it coincides with every vsync lead.
    sysRstN = 1'b0;
    #1;
    hStart  = 0;
    lineIdx = 0;
    pix     = 0;
    applyStimulus(3);
    sysRstN = 1'b1;
    runToNext(V_START, 0);
    applyStimulus(3);
    checkOutput("coinc VPos/A", vtA.VPos, 1);
    checkOutput("coinc VPos/B", vtB.VPos, 1);
    checkOutput("coinc HPos/A", vtA.HPos, 0);
    checkOutput("coinc FrameStart/A", vtA.FrameStart, 1);
    applyStimulus(1);
    checkOutput("coinc next VPos/A", vtA.VPos, 1);
    checkOutput("coinc next HPos/A", vtA.HPos, 1);
    runToNext(V_START, 0);
    applyStimulus(3);
    checkOutput("coinc FrameLen/A", vtA.FrameLen, 20);
    checkOutput("coinc FrameLen/B", vtB.FrameLen, 20);
    runToNext(V_START, 0);
    applyStimulus(2);
    checkLock("coinc-lock-2clk", 0, 0);
    applyStimulus(1);
    checkLock("coinc-lock-3clk", 1, 0);
    runToNext(19, 0);
    checkMeas("coinc", 80, 8, 20, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errCount);
    $finish;
  end
endmodule
